// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen: serial pattern transmitter.
//
// A job (pattern, bit length, repeat count) is loaded through a valid/ready
// handshake and then shifted out MSB-first, one bit per clock, with the
// repetitions sent back-to-back. A one-cycle done pulse marks the end of a job.
// The serial output feeds the din input of the 110 / 1101 sequence detectors.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   load_valid in   request to load a new job
//   load_ready out  high only in IDLE
//   pattern    in   [WIDTH] pattern bits, bit len-1 sent first
//   len        in   [LEN_W] bits per repetition (0 or >WIDTH means WIDTH)
//   reps       in   [CNT_W] repetitions (0 means 1)
//   abort      in   terminates a job in progress
//   dout       out  serial data bit
//   dout_valid out  dout carries a pattern bit this cycle
//   busy       out  job in progress
//   done       out  one-cycle pulse after the last bit of a job
//   dbg_state  out  [2] current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: a job is accepted on a rising clock edge where load_valid and
// load_ready are both high. load_ready is registered and is high exactly in
// IDLE, so the producer may hold load_valid with stable fields until that
// edge; anything presented while load_ready is low is ignored.
// -----------------------------------------------------------------------------
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] BIT0_SEL = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;      // effective length L
    logic [CNT_W-1:0] reps_q, reps_d;    // effective repeat count N
    logic [LEN_W-1:0] idx_q, idx_d;      // index of the bit being presented
    logic [CNT_W-1:0] rep_q, rep_d;      // current repetition, 1..N
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_ready_q, load_ready_d;

    logic [LEN_W-1:0] len_eff;
    logic [CNT_W-1:0] reps_eff;
    logic [WIDTH-1:0] sel_pat;

    always_comb begin
        // Field normalisation applied at accept time.
        len_eff  = ((len == '0) || (len > LEN_MAX)) ? LEN_MAX : len;
        reps_eff = (reps == '0) ? CNT_ONE : reps;

        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        reps_d       = reps_q;
        idx_d        = idx_q;
        rep_d        = rep_q;
        dout_valid_d = dout_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_ready_d = load_ready_q;
        // On the accept edge the pattern register is not loaded yet, so the
        // first bit is taken straight from the input.
        sel_pat      = pat_q;

        case (state_q)
            S_IDLE: begin
                // abort is deliberately not looked at here.
                if (load_valid) begin
                    state_d      = S_SHIFT;
                    pat_d        = pattern;
                    len_d        = len_eff;
                    reps_d       = reps_eff;
                    idx_d        = len_eff - LEN_ONE;
                    rep_d        = CNT_ONE;
                    sel_pat      = pattern;
                    dout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    load_ready_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d      = S_IDLE;
                    dout_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    load_ready_d = 1'b1;
                end else if (idx_q == '0) begin
                    if (rep_q == reps_q) begin
                        state_d      = S_DONE;
                        dout_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        // Wrap to the MSB of the next repetition, no gap.
                        rep_d = rep_q + CNT_ONE;
                        idx_d = len_q - LEN_ONE;
                    end
                end else begin
                    idx_d = idx_q - LEN_ONE;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                load_ready_d = 1'b1;
            end
            default: begin
                state_d      = S_IDLE;
                dout_valid_d = 1'b0;
                busy_d       = 1'b0;
                load_ready_d = 1'b1;
            end
        endcase

        // dout is registered: it carries the bit selected for the next cycle
        // and is forced low whenever the next state is not SHIFT.
        dout_d = (state_d == S_SHIFT) ? |(sel_pat & (BIT0_SEL << idx_d)) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            reps_q       <= '0;
            idx_q        <= '0;
            rep_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            reps_q       <= reps_d;
            idx_q        <= idx_d;
            rep_q        <= rep_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen: directed self-checking bench for seq_gen.
// Expected serial bits are pushed to exp_q when a job is driven and popped
// whenever the DUT raises dout_valid. Outputs are sampled 1 time unit after
// each rising edge; inputs are driven at the same point.
// -----------------------------------------------------------------------------
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  logic [0:0] exp_q[$];
  int n_errors  = 0;
  int n_checks  = 0;
  int done_seen = 0;

  seq_gen #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pattern    (pattern),
    .len        (len),
    .reps       (reps),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and score the serial output.
  task automatic tick();
    logic [0:0] e;
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
    if (dout_valid === 1'b1) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout_bit", dout, e);
      end
    end else begin
      chk("dout_zero", dout, 0);
    end
  endtask

  // Called in the first cycle after the accept edge.
  task automatic wait_done(input int exp_l, input int exp_n);
    int cyc  = 1;
    int vcnt = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (dout_valid === 1'b1) vcnt++;
      tick();
      cyc++;
    end
    chk("done_latency", cyc, exp_l * exp_n + 1);
    chk("valid_run", vcnt, exp_l * exp_n);
    chk("sb_drained", exp_q.size(), 0);
    chk("done_valid_low", dout_valid, 0);
    chk("done_busy_low", busy, 0);
    chk("done_ready_low", load_ready, 0);
    tick();
    chk("done_single", done, 0);
    chk("ready_back", load_ready, 1);
  endtask

  task automatic push_bits(input logic [7:0] p, input int exp_l, input int exp_n);
    for (int k = 0; k < exp_n; k++)
      for (int b = exp_l - 1; b >= 0; b--)
        exp_q.push_back(p[b]);
  endtask

  task automatic send_job(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                          input int exp_l, input int exp_n, input logic ab);
    push_bits(p, exp_l, exp_n);
    chk("ready_idle", load_ready, 1);
    pattern    = p;
    len        = l;
    reps       = r;
    load_valid = 1'b1;
    abort      = ab;
    tick();
    load_valid = 1'b0;
    abort      = 1'b0;
    // Captured fields must not follow the inputs.
    pattern    = 8'($urandom_range(0, 255));
    len        = 4'($urandom_range(0, 15));
    reps       = 4'($urandom_range(0, 15));
    chk("ready_drop", load_ready, 0);
    chk("busy_set", busy, 1);
    wait_done(exp_l, exp_n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, load_ready, 1);
  endtask

  initial begin
    int d0;
    logic [7:0] rnd;
    rst        = 1'b1;
    load_valid = 1'b0;
    pattern    = 8'h00;
    len        = 4'd0;
    reps       = 4'd0;
    abort      = 1'b0;

    // reset
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // single 1101
    send_job(8'h0D, 4'd4, 4'd1, 4, 1, 1'b0);

    // repeat 110 three times
    send_job(8'h06, 4'd3, 4'd3, 3, 3, 1'b0);

    // normalisation: len=0/reps=0, then len clamped
    send_job(8'hA5, 4'd0, 4'd0, 8, 1, 1'b0);
    send_job(8'hA5, 4'd12, 4'd0, 8, 1, 1'b0);

    // boundaries: one-bit pattern at maximum repeat count, random full width
    send_job(8'h01, 4'd1, 4'd15, 1, 15, 1'b0);
    rnd = 8'($urandom_range(0, 255));
    send_job(rnd, 4'd8, 4'd2, 8, 2, 1'b0);

    // abort together with load in IDLE: load wins
    send_job(8'h0D, 4'd4, 4'd1, 4, 1, 1'b1);

    // busy-ignore: second request held throughout the first job
    push_bits(8'h0D, 4, 2);
    pattern    = 8'h0D;
    len        = 4'd4;
    reps       = 4'd2;
    load_valid = 1'b1;
    tick();
    pattern = 8'hF0;
    len     = 4'd8;
    reps    = 4'd1;
    chk("bi_busy", busy, 1);
    wait_done(4, 2);
    chk("bi_idle_not_busy", busy, 0);
    push_bits(8'hF0, 8, 1);
    tick();
    load_valid = 1'b0;
    chk("bi_second_accept", busy, 1);
    wait_done(8, 1);

    // abort on the 3rd bit of an 8-bit job
    push_bits(8'hA5, 3, 1);
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    pattern    = 8'hA5;
    len        = 4'd8;
    reps       = 4'd1;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk("ab_third_bit_valid", dout_valid, 1);
    d0    = done_seen;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_reset_outputs("ab");
    tick();
    tick();
    tick();
    chk("ab_no_done", done_seen, d0);
    chk("ab_sb_drained", exp_q.size(), 0);

    // mid-stream reset
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    pattern    = 8'h06;
    len        = 4'd3;
    reps       = 4'd3;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    d0  = done_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("mr");
    tick();
    tick();
    chk("mr_no_done", done_seen, d0);
    chk("mr_sb_drained", exp_q.size(), 0);
    send_job(8'h0D, 4'd4, 4'd1, 4, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
